tempo_sequencer: RTL and testbench
==================================

# tempo_sequencer

Parametrised note-step tempo generator for the audio path. It converts a runtime BPM and a speed mode into a per-note `tick` pulse and tracks the current note index for the song ROM FSM. It sits between the game controller and the song FSM/audio codec. On top of the fixed-divisor rate divider it adds:
- a sequential divider, so any BPM is exact;
- glitch-free tempo change mid-song;
- beat subdivision;
- loop mode;
- an internally generated `done`.

## Interface
- CLOCK_FREQUENCY, 50000000, system clock rate in Hz
- BPM_W, 16, width of bpm input
- COUNT_W, 32, width of period counter/quotient
- SUBDIV, 4, note ticks per beat (≥1)
- NOTE_W, 16, width of note index and song length
- DIV_W, 40 (localparam), dividend/divider width; divide takes DIV_W cycles

Ports:
- clk  in  1  system clock
- Reset  in  1  asynchronous, active-high; clock clk
- play  in  1  level; high runs the song, low returns to IDLE
- bpm  in  BPM_W  beats per minute, runtime
- speed  in  2  00=0.5x, 01=0.75x, 10=1x, 11=2x
- song_len  in  NOTE_W  number of notes in the song
- loop  in  1  1 = wrap to note 0 at end, 0 = stop
- tick  out  1  one-cycle pulse at the start of each note
- beat  out  1  one-cycle pulse, coincident with tick, when new note_index % SUBDIV == 0
- note_index  out  NOTE_W  current note, valid from first tick
- busy  out  1  divider in progress
- done  out  1  song finished (non-loop); held until play low

## Operation
- States: IDLE, CALC, RUN, DONE.
- Reset (async) and play low (sync, any state) force IDLE and zero all outputs, counters, period registers and divider.
- Period in cycles: P = floor(N/D).
  - N = CLOCK_FREQUENCY·60·{2,4,1,1}[speed].
  - D = bpm·SUBDIV·{1,3,1,2}[speed].
  - Computed by a restoring divider, one quotient bit per cycle, DIV_W cycles.
  - Quotient > 2^COUNT_W−1 saturates; P = 0 is clamped to 1.
- IDLE → CALC when play is high and bpm ≠ 0. With bpm = 0, stay in IDLE.
- CALC → RUN when the divide completes and song_len ≠ 0. In the same cycle, P is latched and the first tick is emitted with note_index = 0 and beat = 1.
- CALC → DONE when the divide completes and song_len = 0. No tick is emitted.
- RUN countdown:
  - The countdown is loaded with P−1 at each tick and decrements each cycle.
  - At 0, the next tick fires and note_index increments.
  - If the new index would equal song_len: with loop = 1, wrap to 0 and tick; with loop = 0, go to DONE and suppress that tick.
- Tempo change in RUN:
  - bpm and speed are compared every cycle against registered copies.
  - On a mismatch, the copies update and the divider (re)starts, aborting any divide in progress. busy is high throughout.
  - The result goes to next_period, which is loaded at the following tick reload. The current interval completes at the old P.
- bpm = 0 in RUN freezes the countdown (no ticks, no divide) until bpm ≠ 0. A recalculation then follows.
- DONE: done = 1, no ticks. Leaves DONE only via play low or Reset.

## Timing
- All outputs are registered. Reset values: tick = 0, beat = 0, note_index = 0, busy = 0, done = 0.
- Start latency:
  - play sampled high in IDLE at edge E → CALC at E+1.
  - The quotient completes after DIV_W edges.
  - tick is high for the single cycle following edge E+DIV_W+1.
- Tick-to-tick spacing is exactly P cycles, or P_new after a tempo change has been latched.
- A tempo change and a tick in the same cycle: the tick reloads with the old next_period. The new value applies one interval later.
- play low on the same edge as a tick: play wins, tick = 0.
- song_len changes mid-song are sampled at each increment.

## Test plan
- CLOCK_FREQUENCY = 6000, SUBDIV = 4, bpm = 60, speed = 10, song_len = 8, loop = 0, play ↑ → first tick 41 cycles after play sampled; ticks every 1500 cycles; beat on indices 0 and 4; done after index 7 with no 9th tick.
- Same setup with speed 11 / 00 / 01 → spacing of 750 / 3000 / 2000 cycles.
- loop = 1, song_len = 3 → index sequence 0,1,2,0,1,…; done stays 0.
- Mid-song bpm 60 → 120 at speed 10 → busy high for 40 cycles; the current interval stays 1500; intervals after the next reload are 750.
- play low mid-interval, then high → immediate IDLE; restart at index 0 with 41-cycle latency. An async Reset pulse mid-CALC clears busy and all outputs without a clock edge.
- bpm = 0 at play ↑ → stays IDLE, no tick; song_len = 0 → done after 41 cycles, no tick.

Source files
------------

// File: rtl/tempo_sequencer_if.sv
// Control/status bundle between the game controller (master) and the
// tempo sequencer (slave): play/tempo/song controls in, note timing out.
interface tempo_sequencer_if #(
  parameter int BPM_W  = 16,
  parameter int NOTE_W = 16
);
  logic              play;
  logic [BPM_W-1:0]  bpm;
  logic [1:0]        speed;
  logic [NOTE_W-1:0] song_len;
  logic              loop;
  logic              tick;
  logic              beat;
  logic [NOTE_W-1:0] note_index;
  logic              busy;
  logic              done;

  modport master (
    output play, bpm, speed, song_len, loop,
    input  tick, beat, note_index, busy, done
  );

  modport slave (
    input  play, bpm, speed, song_len, loop,
    output tick, beat, note_index, busy, done
  );
endinterface

// File: rtl/tempo_sequencer.sv
// Note-step tempo generator: derives the note period from bpm/speed with a
// sequential restoring divider, then emits one tick per note, a beat every
// SUBDIV notes, tracks the note index and signals end of song.
module tempo_sequencer #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BPM_W           = 16,
  parameter int COUNT_W         = 32,
  parameter int SUBDIV          = 4,
  parameter int NOTE_W          = 16
) (
  input logic              clk,
  input logic              Reset,
  tempo_sequencer_if.slave bus
);
  localparam int DIV_W = 40;
  localparam int CW    = $clog2(DIV_W + 1);
  localparam int SW    = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;
  localparam int NW1   = NOTE_W + 1;
  localparam logic [DIV_W-1:0] N_BASE = DIV_W'(64'(CLOCK_FREQUENCY) * 64'd60);

  typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [BPM_W-1:0]    bpm_q;
  logic [1:0]          speed_q;
  logic [DIV_W-1:0]    div_rem, div_quo, div_den;
  logic [CW-1:0]       div_cnt;
  logic                busy_r, div_fin;
  logic [COUNT_W-1:0]  period_nx, cnt;
  logic [NOTE_W-1:0]   idx;
  logic [SW-1:0]       sub_cnt;
  logic                tick_r, beat_r, done_r;

  logic                div_start, div_kill, first_tick, cnt_run;
  logic                tempo_diff, at_end, note_due;
  logic [DIV_W:0]      rem_sh;
  logic [DIV_W-1:0]    rem_nx, quo_nx;
  logic [NOTE_W-1:0]   idx_inc;
  logic [SW-1:0]       sub_nx;

  // Dividend: clock cycles per minute scaled by the speed numerator.
  function automatic logic [DIV_W-1:0] numer(input logic [1:0] s);
    case (s)
      2'b00:   numer = N_BASE << 1;
      2'b01:   numer = N_BASE << 2;
      default: numer = N_BASE;
    endcase
  endfunction

  // Divisor: note ticks per minute scaled by the speed denominator.
  function automatic logic [DIV_W-1:0] denom(input logic [BPM_W-1:0] b, input logic [1:0] s);
    logic [DIV_W-1:0] base;
    base = DIV_W'(b) * DIV_W'(SUBDIV);
    case (s)
      2'b01:   denom = base + (base << 1);
      2'b11:   denom = base << 1;
      default: denom = base;
    endcase
  endfunction

  // Saturate oversize quotients and keep the period at least one cycle.
  function automatic logic [COUNT_W-1:0] sat_period(input logic [DIV_W-1:0] q);
    if (q > DIV_W'({COUNT_W{1'b1}}))
      sat_period = '1;
    else if (q == '0)
      sat_period = COUNT_W'(1);
    else
      sat_period = q[COUNT_W-1:0];
  endfunction

  assign tempo_diff = (bus.bpm != bpm_q) || (bus.speed != speed_q);
  assign at_end     = ({1'b0, idx} + NW1'(1)) >= {1'b0, bus.song_len};
  assign note_due   = cnt_run && (cnt == '0);
  assign idx_inc    = idx + NOTE_W'(1);
  assign sub_nx     = (sub_cnt == SW'(SUBDIV - 1)) ? '0 : sub_cnt + SW'(1);

  assign bus.tick       = tick_r;
  assign bus.beat       = beat_r;
  assign bus.note_index = idx;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {div_rem, div_quo[DIV_W-1]};
    if (rem_sh >= {1'b0, div_den}) begin
      rem_nx = DIV_W'(rem_sh - {1'b0, div_den});
      quo_nx = {div_quo[DIV_W-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[DIV_W-1:0];
      quo_nx = {div_quo[DIV_W-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and control strobes; play low overrides everything.
  always_comb begin
    state_nx   = state;
    div_start  = 1'b0;
    div_kill   = 1'b0;
    first_tick = 1'b0;
    cnt_run    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.bpm != '0) begin
          state_nx  = CALC;
          div_start = 1'b1;
        end
      end
      CALC: begin
        if (div_fin) begin
          if (bus.song_len != '0) begin
            state_nx   = RUN;
            first_tick = 1'b1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      RUN: begin
        if (bus.bpm == '0) begin
          div_kill = 1'b1;
        end else begin
          cnt_run = 1'b1;
          if ((cnt == '0) && at_end && !bus.loop)
            state_nx = DONE;
          else
            div_start = tempo_diff;
        end
      end
      default: ;
    endcase
    if (!bus.play) begin
      state_nx   = IDLE;
      div_start  = 1'b0;
      div_kill   = 1'b0;
      first_tick = 1'b0;
      cnt_run    = 1'b0;
    end
  end

  // Divider: (re)start latches the tempo copies; a bpm of zero aborts it and
  // clears the bpm copy so a fresh divide follows once bpm returns.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      bpm_q   <= '0;
      speed_q <= '0;
      div_rem <= '0;
      div_quo <= '0;
      div_den <= '0;
      div_cnt <= '0;
      busy_r  <= 1'b0;
      div_fin <= 1'b0;
    end else if (!bus.play) begin
      bpm_q   <= '0;
      speed_q <= '0;
      div_rem <= '0;
      div_quo <= '0;
      div_den <= '0;
      div_cnt <= '0;
      busy_r  <= 1'b0;
      div_fin <= 1'b0;
    end else if (div_start) begin
      bpm_q   <= bus.bpm;
      speed_q <= bus.speed;
      div_rem <= '0;
      div_quo <= numer(bus.speed);
      div_den <= denom(bus.bpm, bus.speed);
      div_cnt <= CW'(DIV_W);
      busy_r  <= 1'b1;
      div_fin <= 1'b0;
    end else if (div_kill) begin
      bpm_q   <= '0;
      busy_r  <= 1'b0;
      div_fin <= 1'b0;
    end else if (busy_r) begin
      div_rem <= rem_nx;
      div_quo <= quo_nx;
      div_cnt <= div_cnt - CW'(1);
      if (div_cnt == CW'(1)) begin
        busy_r  <= 1'b0;
        div_fin <= 1'b1;
      end
    end else begin
      div_fin <= 1'b0;
    end
  end

  // Note timing: period latch, countdown, note index, beat phase and outputs.
  // A fresh quotient lands in period_nx and only takes effect at the next reload.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      period_nx <= '0;
      cnt       <= '0;
      idx       <= '0;
      sub_cnt   <= '0;
      tick_r    <= 1'b0;
      beat_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (!bus.play) begin
      period_nx <= '0;
      cnt       <= '0;
      idx       <= '0;
      sub_cnt   <= '0;
      tick_r    <= 1'b0;
      beat_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      beat_r <= 1'b0;
      done_r <= (state_nx == DONE);
      if ((state == RUN) && div_fin)
        period_nx <= sat_period(div_quo);
      if (first_tick) begin
        period_nx <= sat_period(div_quo);
        cnt       <= sat_period(div_quo) - COUNT_W'(1);
        idx       <= '0;
        sub_cnt   <= '0;
        tick_r    <= 1'b1;
        beat_r    <= 1'b1;
      end else if (note_due) begin
        cnt <= period_nx - COUNT_W'(1);
        if (at_end) begin
          if (bus.loop) begin
            idx     <= '0;
            sub_cnt <= '0;
            tick_r  <= 1'b1;
            beat_r  <= 1'b1;
          end
        end else begin
          idx     <= idx_inc;
          sub_cnt <= sub_nx;
          tick_r  <= 1'b1;
          beat_r  <= (sub_nx == '0);
        end
      end else if (cnt_run) begin
        cnt <= cnt - COUNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_tempo_sequencer.sv
// Directed + randomized bench for tempo_sequencer with a small arithmetic
// model of the note period and the note index sequence.
module tb_tempo_sequencer;
  localparam int CLK_HZ = 6000;

  logic   clk = 1'b0;
  logic   Reset;
  longint cyc = 0;
  int     vectors = 0;
  int     errors  = 0;

  tempo_sequencer_if #(.BPM_W(16), .NOTE_W(16)) tb_if ();

  tempo_sequencer #(
    .CLOCK_FREQUENCY(CLK_HZ), .BPM_W(16), .COUNT_W(32), .SUBDIV(4), .NOTE_W(16)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (tb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Period from the tempo rules: floor(f*60*num / (bpm*SUBDIV*den)), clamped.
  function automatic longint model_period(input int b, input int s);
    longint num, den, p;
    num = longint'(CLK_HZ) * 60 * ((s == 0) ? 2 : (s == 1) ? 4 : 1);
    den = longint'(b) * 4 * ((s == 1) ? 3 : (s == 3) ? 2 : 1);
    p = num / den;
    if (p < 1) p = 1;
    if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
    return p;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next cycle showing tick or done; at = -1 on timeout.
  task automatic wait_ev(input int limit, output longint at, output bit saw_tick, output bit saw_done);
    at = -1;
    saw_tick = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tb_if.tick || tb_if.done) begin
        at = cyc;
        saw_tick = tb_if.tick;
        saw_done = tb_if.done;
        break;
      end
    end
  endtask

  // Return to IDLE, load song settings and raise play; c0 = cycle count before the sampling edge.
  task automatic start_song(input int b, input int s, input int len, input bit lp, output longint c0);
    @(negedge clk);
    tb_if.play = 1'b0;
    @(negedge clk);
    tb_if.bpm      = 16'(b);
    tb_if.speed    = 2'(s);
    tb_if.song_len = 16'(len);
    tb_if.loop     = lp;
    tb_if.play     = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    longint c0, at, prev, p;
    bit     st, sd;
    int     exp_idx, nt, nb, b, s, len;
    int     speeds[3] = '{3, 0, 1};

    Reset = 1'b1;
    tb_if.play = 1'b0;
    tb_if.bpm = '0;
    tb_if.speed = '0;
    tb_if.song_len = '0;
    tb_if.loop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tick", tb_if.tick, 0);
    chk("reset_beat", tb_if.beat, 0);
    chk("reset_index", tb_if.note_index, 0);
    chk("reset_busy", tb_if.busy, 0);
    chk("reset_done", tb_if.done, 0);
    Reset = 1'b0;

    // Basic song: 8 notes at 60 bpm, 1x, no loop.
    start_song(60, 2, 8, 1'b0, c0);
    wait_ev(200, at, st, sd);
    chk("first_latency", at - (c0 + 1), 41);
    chk("first_is_tick", st, 1);
    chk("first_index", tb_if.note_index, 0);
    chk("first_beat", tb_if.beat, 1);
    p = model_period(60, 2);
    prev = at;
    for (int k = 1; k < 8; k++) begin
      wait_ev(int'(p) + 20, at, st, sd);
      chk("spacing_1x", at - prev, p);
      chk("index_1x", tb_if.note_index, k);
      chk("beat_1x", tb_if.beat, ((k % 4) == 0) ? 1 : 0);
      prev = at;
    end
    wait_ev(int'(p) + 20, at, st, sd);
    chk("end_done", sd, 1);
    chk("end_no_tick", st, 0);
    chk("end_time", at - prev, p);
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tb_if.tick) nt++;
    end
    chk("done_no_ticks", nt, 0);
    chk("done_held", tb_if.done, 1);

    // Other speed modes.
    for (int j = 0; j < 3; j++) begin
      start_song(60, speeds[j], 8, 1'b0, c0);
      wait_ev(200, at, st, sd);
      chk("speed_latency", at - (c0 + 1), 41);
      p = model_period(60, speeds[j]);
      prev = at;
      for (int k = 0; k < 2; k++) begin
        wait_ev(int'(p) + 20, at, st, sd);
        chk("speed_spacing", at - prev, p);
        prev = at;
      end
    end

    // Randomized tempo and short looping songs.
    for (int r = 0; r < 3; r++) begin
      b   = int'($urandom_range(400, 120));
      s   = int'($urandom_range(3, 0));
      len = int'($urandom_range(4, 2));
      start_song(b, s, len, 1'b1, c0);
      wait_ev(200, at, st, sd);
      chk("rand_latency", at - (c0 + 1), 41);
      p = model_period(b, s);
      prev = at;
      exp_idx = 0;
      for (int k = 0; k < 4; k++) begin
        wait_ev(int'(p) + 20, at, st, sd);
        exp_idx = (exp_idx + 1) % len;
        chk("rand_spacing", at - prev, p);
        chk("rand_index", tb_if.note_index, exp_idx);
        chk("rand_beat", tb_if.beat, ((exp_idx % 4) == 0) ? 1 : 0);
        prev = at;
      end
    end

    // Loop mode, 3 notes.
    start_song(600, 2, 3, 1'b1, c0);
    wait_ev(200, at, st, sd);
    p = model_period(600, 2);
    exp_idx = 0;
    chk("loop_first_index", tb_if.note_index, 0);
    for (int k = 0; k < 6; k++) begin
      wait_ev(int'(p) + 20, at, st, sd);
      exp_idx = (exp_idx + 1) % 3;
      chk("loop_is_tick", st, 1);
      chk("loop_index", tb_if.note_index, exp_idx);
      chk("loop_done_low", tb_if.done, 0);
    end

    // Mid-song tempo change 60 -> 120 bpm.
    start_song(60, 2, 8, 1'b0, c0);
    wait_ev(200, at, st, sd);
    prev = at;
    repeat (100) @(negedge clk);
    tb_if.bpm = 16'd120;
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tb_if.busy) nb++;
    end
    chk("change_busy_cycles", nb, 40);
    wait_ev(2000, at, st, sd);
    chk("change_old_interval", at - prev, model_period(60, 2));
    prev = at;
    for (int k = 0; k < 2; k++) begin
      wait_ev(2000, at, st, sd);
      chk("change_new_interval", at - prev, model_period(120, 2));
      prev = at;
    end

    // play low mid-interval, then restart.
    repeat (200) @(negedge clk);
    tb_if.play = 1'b0;
    @(negedge clk);
    chk("stop_index", tb_if.note_index, 0);
    chk("stop_tick", tb_if.tick, 0);
    chk("stop_busy", tb_if.busy, 0);
    chk("stop_done", tb_if.done, 0);
    start_song(120, 2, 8, 1'b0, c0);
    wait_ev(200, at, st, sd);
    chk("restart_latency", at - (c0 + 1), 41);
    chk("restart_index", tb_if.note_index, 0);

    // Asynchronous Reset in the middle of a divide.
    start_song(60, 2, 8, 1'b0, c0);
    repeat (10) @(negedge clk);
    chk("calc_busy", tb_if.busy, 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_busy", tb_if.busy, 0);
    chk("async_tick", tb_if.tick, 0);
    chk("async_done", tb_if.done, 0);
    @(negedge clk);
    tb_if.play = 1'b0;
    Reset = 1'b0;

    // bpm = 0 never leaves IDLE.
    start_song(0, 2, 8, 1'b0, c0);
    wait_ev(80, at, st, sd);
    chk("bpm0_no_event", at, -1);
    chk("bpm0_busy", tb_if.busy, 0);

    // Empty song goes straight to done.
    start_song(60, 2, 0, 1'b0, c0);
    wait_ev(200, at, st, sd);
    chk("empty_done", sd, 1);
    chk("empty_no_tick", st, 0);
    chk("empty_latency", at - (c0 + 1), 41);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
